// File: rtl/troca_contexto_pc_pkg.sv
// Shared parameters, FSM encoding and helpers for the context-switch PC unit.
package troca_contexto_pc_pkg;

  localparam int TAM_BLOCO = 200;
  localparam int NUM_PROC  = 4;
  localparam int PC_W      = 11;
  localparam int PROC_W    = 2;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    SALVA   = 2'd1,
    CARREGA = 2'd2,
    CONCLUI = 2'd3
  } estado_t;

  // Out-of-range process ids fall back to process 0.
  function automatic logic [PROC_W-1:0] saneia_proc(input logic [PROC_W-1:0] p);
    logic [31:0] p_ext;
    p_ext = 32'(p);
    return (p_ext >= 32'(NUM_PROC)) ? '0 : p;
  endfunction

endpackage

// File: rtl/troca_contexto_pc_if.sv
// Scheduler <-> context-switch unit signal bundle.
interface troca_contexto_pc_if;
  import troca_contexto_pc_pkg::*;

  logic              troca_req;
  logic [PROC_W-1:0] proc_prox;
  logic [PC_W-1:0]   pc_fisico_atual;
  logic              troca_ack;
  logic [PC_W-1:0]   pc_fisico_novo;
  logic [PROC_W-1:0] processo_atual;
  logic              erro_limite;

  modport master (
    output troca_req, proc_prox, pc_fisico_atual,
    input  troca_ack, pc_fisico_novo, processo_atual, erro_limite
  );

  modport slave (
    input  troca_req, proc_prox, pc_fisico_atual,
    output troca_ack, pc_fisico_novo, processo_atual, erro_limite
  );
endinterface

// File: rtl/troca_contexto_pc_calculo_base_processo.sv
// Block base of a process plus physical->logical and logical->physical mapping.
module calculo_base_processo
  import troca_contexto_pc_pkg::*;
(
  input  logic [PROC_W-1:0] proc,
  input  logic [PC_W-1:0]   pc_fisico,
  input  logic [PC_W-1:0]   pc_logico,
  output logic [PC_W-1:0]   logico,
  output logic [PC_W-1:0]   fisico,
  output logic              fora_limite
);
  logic [PC_W-1:0] base;

  always_comb begin
    base        = PC_W'(PC_W'(proc) * PC_W'(TAM_BLOCO));
    logico      = pc_fisico - base;
    fisico      = pc_logico + base;
    fora_limite = (pc_fisico < base) || (logico >= PC_W'(TAM_BLOCO));
  end
endmodule

// File: rtl/troca_contexto_pc.sv
// Context-switch PC unit: saves outgoing logical PC, reloads/relocates incoming one.
// Optional switch counter output num_trocas enabled by macro CONTADOR_TROCAS_EN.
module troca_contexto_pc
  import troca_contexto_pc_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  troca_contexto_pc_if.slave  bus
`ifdef CONTADOR_TROCAS_EN
  ,
  output logic [15:0]         num_trocas
`endif
);
  estado_t           estado, estado_prox;
  logic [PC_W-1:0]   pc_lat;
  logic [PROC_W-1:0] proc_lat;
  logic [PC_W-1:0]   tabela [NUM_PROC];
  logic [PROC_W-1:0] proc_atual;
  logic [PC_W-1:0]   pc_novo;
  logic              ack;
  logic              erro;

  logic [PROC_W-1:0] proc_sel;
  logic [PC_W-1:0]   logico, fisico;
  logic              fora;

  // One mapper is shared: SALVA maps the outgoing process, CARREGA the incoming one.
  always_comb proc_sel = (estado == SALVA) ? proc_atual : proc_lat;

  calculo_base_processo u_calc (
    .proc        (proc_sel),
    .pc_fisico   (pc_lat),
    .pc_logico   (tabela[proc_lat]),
    .logico      (logico),
    .fisico      (fisico),
    .fora_limite (fora)
  );

  always_ff @(posedge clock) begin
    if (reset) estado <= OCIOSO;
    else       estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:  if (bus.troca_req) estado_prox = SALVA;
      SALVA:   estado_prox = CARREGA;
      CARREGA: estado_prox = CONCLUI;
      CONCLUI: estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_lat     <= '0;
      proc_lat   <= '0;
      proc_atual <= '0;
      pc_novo    <= '0;
      ack        <= 1'b0;
      erro       <= 1'b0;
      for (int i = 0; i < NUM_PROC; i++) tabela[i] <= '0;
    end else begin
      ack <= 1'b0;
      case (estado)
        OCIOSO: if (bus.troca_req) begin
          pc_lat   <= bus.pc_fisico_atual;
          proc_lat <= saneia_proc(bus.proc_prox);
          erro     <= 1'b0;
        end
        SALVA: begin
          tabela[proc_atual] <= fora ? '0 : logico;
          if (fora) erro <= 1'b1;
        end
        CARREGA: pc_novo <= fisico;
        CONCLUI: begin
          proc_atual <= proc_lat;
          ack        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CONTADOR_TROCAS_EN
  logic [15:0] contador;
  always_ff @(posedge clock) begin
    if (reset)                                         contador <= '0;
    else if (estado == CONCLUI && contador != 16'hFFFF) contador <= contador + 16'd1;
  end
  assign num_trocas = contador;
`endif

  assign bus.troca_ack      = ack;
  assign bus.pc_fisico_novo = pc_novo;
  assign bus.processo_atual = proc_atual;
  assign bus.erro_limite    = erro;
endmodule
